// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue between IF and ID with a single-outstanding memory port.
// Define IPB_PERF_CNT_EN to add the fetch_cnt/drop_cnt performance counters.
module inst_prefetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef IPB_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state;
    logic [31:0]   fetchPc;
    logic [31:0]   memAddr;
    logic [CW-1:0] count;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [31:0]   instrQ [DEPTH];
    logic [31:0]   pc4Q   [DEPTH];

    logic          push;
    logic          pop;
    logic [CW-1:0] nextCount;
    logic [31:0]   addrInc;

    assign addrInc   = memAddr + 32'd4;
    assign out_valid = (count != '0);
    assign pop       = out_valid & ~stall & ~redirect;
    assign push      = (state == REQ) & mem_ack & ~redirect;
    assign nextCount = count + CW'(push) - CW'(pop);

    assign mem_req   = (state != IDLE);
    assign mem_addr  = memAddr;
    // Gate the head so stale storage never shows while empty or in reset
    assign out_instr = out_valid ? instrQ[rdPtr] : 32'h0;
    assign out_pc4   = out_valid ? pc4Q[rdPtr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            instrQ[wrPtr] <= mem_rdata;
            pc4Q[wrPtr]   <= addrInc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            memAddr <= 32'h0;
            count   <= '0;
            rdPtr   <= '0;
            wrPtr   <= '0;
        end else if (redirect) begin
            count   <= '0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            fetchPc <= redirect_pc;
            unique case (state)
                IDLE: state <= IDLE;
                REQ:  state <= mem_ack ? IDLE : DROP;
                DROP: if (mem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end else begin
            count <= nextCount;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            unique case (state)
                IDLE: begin
                    if (nextCount < DEPTH_C) begin
                        state   <= REQ;
                        memAddr <= {fetchPc[31:2], 2'b00};
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        fetchPc <= addrInc;
                        if (nextCount < DEPTH_C) memAddr <= addrInc;
                        else                     state   <= IDLE;
                    end
                end
                DROP: if (mem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IPB_PERF_CNT_EN
    logic discard;
    assign discard = mem_ack & ((state == DROP) | ((state == REQ) & redirect));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= 32'h0;
            drop_cnt  <= 16'h0;
        end else begin
            fetch_cnt <= fetch_cnt + 32'(push);
            drop_cnt  <= drop_cnt + (redirect ? 16'(count) : 16'h0)
                       + 16'(discard);
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed bench for inst_prefetch_buf with a parametrised-latency memory model.
// Memory returns mem_addr ^ K so every word identifies its own address.
module tb_inst_prefetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef IPB_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int ackWait;
    int waitCnt;

    localparam logic [31:0] K = 32'h1300_0000;

    inst_prefetch_buf #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .stall(stall),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc4(out_pc4),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
`ifdef IPB_PERF_CNT_EN
        ,
        .fetch_cnt(fetch_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign mem_ack   = mem_req && (waitCnt == ackWait);
    assign mem_rdata = mem_addr ^ K;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     waitCnt <= 0;
        else if (mem_req && !mem_ack) waitCnt <= waitCnt + 1;
        else                         waitCnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int w, input logic s);
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = s;
        ackWait     = w;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        ackWait     = 0;
        #2;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_req",   32'(mem_req),   32'h0);
        check("rst_instr", out_instr,      32'h0);
        check("rst_pc4",   out_pc4,        32'h0);

        // streaming from reset, zero-wait memory
        doReset(0, 1'b0);
        check("idle_req", 32'(mem_req), 32'h0);
        tick;
        check("first_addr", mem_addr, 32'h0);
        check("first_req", 32'(mem_req), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            tick;
            check("seq_pc4",   out_pc4,   32'(4 * i));
            check("seq_instr", out_instr, 32'(4 * (i - 1)) ^ K);
            check("seq_addr",  mem_addr,  32'(4 * i));
        end

        // stall fills the queue and stops fetching
        stall = 1'b1;
        tick; tick; tick;
        check("full_req", 32'(mem_req), 32'h0);
        tick; tick;
        check("full_req2", 32'(mem_req), 32'h0);
        check("full_head", out_pc4, 32'd16);
        stall = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick;
            check("drain_pc4", out_pc4, 32'(16 + 4 * i));
        end

        // three wait-state memory
        doReset(3, 1'b1);
        tick;
        check("slow_addr0", mem_addr, 32'h0);
        tick;
        check("slow_hold", mem_addr, 32'h0);
        check("slow_noack", 32'(mem_ack), 32'h0);
        tick;
        check("slow_noack2", 32'(mem_ack), 32'h0);
        tick;
        check("slow_ack", 32'(mem_ack), 32'h1);
        tick;
        check("slow_addr4", mem_addr, 32'h4);
        check("slow_pc4", out_pc4, 32'h4);
        tick; tick;
        check("slow_hold4", mem_addr, 32'h4);
        tick;
        check("slow_ack4", 32'(mem_ack), 32'h1);
        tick;
        check("slow_addr8", mem_addr, 32'h8);
        #2;
        rst = 1'b1;
        #1;
        check("async_req", 32'(mem_req), 32'h0);
        check("async_valid", 32'(out_valid), 32'h0);

        // redirect while a request to 0x20 is pending
        doReset(3, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        tick;
        redirect = 1'b0;
        check("rd_idle", 32'(mem_req), 32'h0);
        tick;
        check("rd_addr20", mem_addr, 32'h20);
        tick;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        stall       = 1'b0;
        tick;
        redirect = 1'b0;
        check("drop_hold", mem_addr, 32'h20);
        check("drop_req", 32'(mem_req), 32'h1);
        for (int k = 0; k < 20 && !(mem_req && mem_addr == 32'h100); k++) tick;
        check("rd_addr100", mem_addr, 32'h100);
        check("rd_dropped", 32'(out_valid), 32'h0);
        for (int k = 0; k < 20 && !out_valid; k++) tick;
        check("rd_pc4", out_pc4, 32'h104);
        check("rd_instr", out_instr, 32'h100 ^ K);

        // push, pop and redirect in the same cycle
        doReset(0, 1'b0);
        tick; tick;
        check("pp_valid", 32'(out_valid), 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick;
        redirect = 1'b0;
        check("pp_empty", 32'(out_valid), 32'h0);
        check("pp_idle", 32'(mem_req), 32'h0);
        tick;
        check("pp_addr", mem_addr, 32'h40);
        tick;
        check("pp_pc4", out_pc4, 32'h44);

        // address wrap at the top of memory
        doReset(0, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick;
        redirect = 1'b0;
        tick;
        check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        tick;
        check("wrap_pc4", out_pc4, 32'h0);
        check("wrap_next", mem_addr, 32'h0);
        check("wrap_instr", out_instr, 32'hFFFF_FFFC ^ K);

`ifdef IPB_PERF_CNT_EN
        doReset(0, 1'b0);
        for (int i = 0; i < 8; i++) tick;
        stall = 1'b1;
        tick; tick; tick;
        ackWait = 100;
        stall   = 1'b0;
        tick;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick;
        redirect = 1'b0;
        check("fetch_cnt", fetch_cnt, 32'd10);
        check("drop_cnt", 32'(drop_cnt), 32'd3);
        doReset(0, 1'b0);
        check("cnt_rst", fetch_cnt, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
